// File: rtl/inst_fifo_pkg.sv
// Shared types for the fetch-to-issue instruction queue.
// One entry carries the PC, the instruction word and the fetch-exception flag.
package inst_fifo_pkg;

    localparam int unsigned ENTRY_W     = 65;
    localparam int unsigned FETCH_WIDTH = 2;
    localparam int unsigned ISSUE_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fifo_ram.sv
// Instruction queue storage: two write ports and two asynchronous read ports.
// The contents are not reset; the pointer logic decides which entries are valid.
module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [AW-1:0] waddr1_i,
    input  fifo_entry_t   wdata0_i,
    input  fifo_entry_t   wdata1_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output fifo_entry_t   rdata0_o,
    output fifo_entry_t   rdata1_o
);

    fifo_entry_t mem_q [DEPTH];

    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_fifo.sv
// Dual-write / dual-read instruction queue between fetch and dual issue.
// Holds the pointer, occupancy, overflow and PC-stall logic around inst_fifo_ram.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH        = 16,
    parameter  int unsigned STALL_MARGIN = 4,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          fifo_flush,
    input  logic          issue_stall,
    input  logic          w_en0,
    input  logic          w_en1,
    input  logic [31:0]   w_pc0,
    input  logic [31:0]   w_pc1,
    input  logic [31:0]   w_inst0,
    input  logic [31:0]   w_inst1,
    input  logic          w_exc0,
    input  logic          w_exc1,
    input  logic          pop0,
    input  logic          pop1,
    output logic          r_valid0,
    output logic          r_valid1,
    output logic [31:0]   r_pc0,
    output logic [31:0]   r_pc1,
    output logic [31:0]   r_inst0,
    output logic [31:0]   r_inst1,
    output logic          r_exc0,
    output logic          r_exc1,
    output logic          fifo_stall_req,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t MARGIN_P = ptr_t'(STALL_MARGIN);

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    logic overflow_q, overflow_d;

    ptr_t cnt;
    ptr_t req_pop, req_wr;
    ptr_t n_pop, n_wr;
    ptr_t free_after;
    logic wr_drop;

    fifo_entry_t wdata0, wdata1, rdata0, rdata1;

    assign cnt = wptr_q - rptr_q;

    // Free space is measured after this cycle's pops so a full queue can
    // accept writes while issue drains it in the same cycle.
    always_comb begin
        req_pop    = ptr_t'(pop0) + ptr_t'(pop1);
        req_wr     = w_en0 ? (ptr_t'(1) + ptr_t'(w_en1)) : '0;
        n_pop      = (issue_stall || fifo_flush) ? '0
                   : ((req_pop > cnt) ? cnt : req_pop);
        free_after = DEPTH_P - (cnt - n_pop);
        n_wr       = (req_wr > free_after) ? free_after : req_wr;
        wr_drop    = (w_en1 && !w_en0) || (req_wr > free_after);

        if (fifo_flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
        end else begin
            wptr_d     = wptr_q + n_wr;
            rptr_d     = rptr_q + n_pop;
            overflow_d = overflow_q || wr_drop;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign wdata0 = '{pc: w_pc0, inst: w_inst0, exc: w_exc0};
    assign wdata1 = '{pc: w_pc1, inst: w_inst1, exc: w_exc1};

    inst_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .we0_i    (!fifo_flush && (n_wr != '0)),
        .we1_i    (!fifo_flush && (n_wr == ptr_t'(2))),
        .waddr0_i (wptr_q[AW-1:0]),
        .waddr1_i (wptr_q[AW-1:0] + AW'(1)),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr0_i (rptr_q[AW-1:0]),
        .raddr1_i (rptr_q[AW-1:0] + AW'(1)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    assign r_valid0       = (cnt != '0);
    assign r_valid1       = (cnt >= ptr_t'(2));
    assign r_pc0          = rdata0.pc;
    assign r_pc1          = rdata1.pc;
    assign r_inst0        = rdata0.inst;
    assign r_inst1        = rdata1.inst;
    assign r_exc0         = rdata0.exc;
    assign r_exc1         = rdata1.exc;
    assign fifo_stall_req = (DEPTH_P - cnt) < MARGIN_P;
    assign count          = cnt;
    assign overflow       = overflow_q;

endmodule
